// File: rtl/data_sram_resp.sv
// -----------------------------------------------------------------------------
// data_sram_resp
//   Word-organised SRAM slave with a one-request-per-cycle interface, address
//   range/alignment checking, response pulses and saturating access counters.
//
//   Optional feature (compile-time macro DSRAM_WAIT_EN):
//     When defined, reads go through an IDLE -> WAIT -> RESP -> IDLE FSM that
//     inserts WAIT_CYCLES extra wait states (read latency 1+WAIT_CYCLES) and
//     raises busy while the read is outstanding. Requests seen while busy are
//     ignored. Writes stay single-cycle and are only accepted in IDLE.
//     When undefined, reads have latency 1 and busy is tied low.
//
// Parameters
//   DEPTH_LOG2  : log2 of the number of 32-bit words
//   BASE_ADDR   : byte address of word 0
//   WAIT_CYCLES : extra read wait states (DSRAM_WAIT_EN builds only)
//
// Ports
//   clk          in   clock, rising edge
//   reset        in   synchronous active-high reset (memory is not cleared)
//   en           in   request valid
//   we           in   1 = write, 0 = read
//   addr[31:0]   in   byte address
//   wdata[31:0]  in   write data
//   rdata[31:0]  out  registered read data, holds between responses
//   rdata_valid  out  one-cycle pulse per read response
//   addr_err     out  one-cycle pulse for an out-of-range/misaligned request
//   busy         out  a delayed read is outstanding
//   rd_cnt[15:0] out  saturating count of accepted in-range reads
//   wr_cnt[15:0] out  saturating count of accepted in-range writes
// -----------------------------------------------------------------------------
module data_sram_resp #(
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h1c00_0000,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        addr_err,
  output logic        busy,
  output logic [15:0] rd_cnt,
  output logic [15:0] wr_cnt
);

  localparam int unsigned DEPTH      = 32'd1 << DEPTH_LOG2;
  // Size of the window in bytes; one extra bit so the top of a 4 GiB window fits.
  localparam logic [32:0] SPAN_BYTES = {1'b0, DEPTH} << 2;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    if (v == 16'hffff) begin
      return v;
    end else begin
      return v + 16'd1;
    end
  endfunction

  logic [31:0]           off_s;
  logic                  in_range_s;
  logic [DEPTH_LOG2-1:0] idx_s;
  logic                  accept_s;
  logic                  rd_acc_s;
  logic                  wr_req_s;
  logic                  wr_acc_s;
  logic                  resp_fire_s;
  logic                  resp_ok_s;
  logic [DEPTH_LOG2-1:0] resp_idx_s;

  logic [31:0]           mem_r [DEPTH];
  logic [31:0]           rdata_r;
  logic                  rdata_valid_r;
  logic                  addr_err_r;
  logic [15:0]           rd_cnt_r;
  logic [15:0]           wr_cnt_r;

  // Offset is only meaningful when addr >= BASE_ADDR; the lower-bound test
  // guards against the subtraction having wrapped.
  assign off_s      = addr - BASE_ADDR;
  assign in_range_s = (addr[1:0] == 2'b00) && (addr >= BASE_ADDR) &&
                      ({1'b0, off_s} < SPAN_BYTES);
  assign idx_s      = off_s[DEPTH_LOG2+1:2];

  assign rd_acc_s   = accept_s && !we;
  assign wr_req_s   = accept_s && we;
  assign wr_acc_s   = wr_req_s && in_range_s;

`ifdef DSRAM_WAIT_EN
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Remaining WAIT cycles after the first one; the FSM leaves WAIT when this hits 0.
  localparam logic [15:0] WAIT_LOAD = (WAIT_CYCLES == 32'd0) ? 16'd0 :
                                      16'(WAIT_CYCLES - 32'd1);

  logic [1:0]            state_r;
  logic [1:0]            state_nxt_s;
  logic [15:0]           wait_cnt_r;
  logic [DEPTH_LOG2-1:0] lat_idx_r;
  logic                  lat_ok_r;
  logic                  busy_r;

  assign accept_s = en && !busy_r;
  assign busy     = busy_r;

  // Next-state decode for the delayed-read FSM.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (rd_acc_s) begin
          state_nxt_s = (WAIT_CYCLES == 32'd0) ? ST_RESP : ST_WAIT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (wait_cnt_r == 16'd0) begin
          state_nxt_s = ST_RESP;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_RESP: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Response registers are loaded on the edge that enters RESP, so the
  // response is visible for exactly the one RESP cycle.
  always_comb begin
    resp_fire_s = 1'b0;
    resp_ok_s   = in_range_s;
    resp_idx_s  = idx_s;
    if ((state_r == ST_WAIT) && (wait_cnt_r == 16'd0)) begin
      resp_fire_s = 1'b1;
      resp_ok_s   = lat_ok_r;
      resp_idx_s  = lat_idx_r;
    end else if (rd_acc_s && (WAIT_CYCLES == 32'd0)) begin
      resp_fire_s = 1'b1;
    end else begin
      resp_fire_s = 1'b0;
    end
  end

  // FSM state, busy flag, wait countdown and latched read request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      busy_r     <= 1'b0;
      wait_cnt_r <= 16'd0;
      lat_idx_r  <= '0;
      lat_ok_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s != ST_IDLE);
      if (rd_acc_s) begin
        wait_cnt_r <= WAIT_LOAD;
        lat_idx_r  <= idx_s;
        lat_ok_r   <= in_range_s;
      end else if ((state_r == ST_WAIT) && (wait_cnt_r != 16'd0)) begin
        wait_cnt_r <= wait_cnt_r - 16'd1;
      end
    end
  end
`else
  assign accept_s    = en;
  assign busy        = 1'b0;
  assign resp_fire_s = rd_acc_s;
  assign resp_ok_s   = in_range_s;
  assign resp_idx_s  = idx_s;
`endif

  // Memory array: written on accepted in-range writes, untouched by reset.
  always_ff @(posedge clk) begin
    if (!reset && wr_acc_s) begin
      mem_r[idx_s] <= wdata;
    end
  end

  // Read response and error pulses; rdata only changes on a read response.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_r       <= 32'h0000_0000;
      rdata_valid_r <= 1'b0;
      addr_err_r    <= 1'b0;
    end else begin
      rdata_valid_r <= resp_fire_s;
      addr_err_r    <= (resp_fire_s && !resp_ok_s) || (wr_req_s && !in_range_s);
      if (resp_fire_s) begin
        rdata_r <= resp_ok_s ? mem_r[resp_idx_s] : 32'h0000_0000;
      end
    end
  end

  // Saturating access counters, bumped at the accepting edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_cnt_r <= 16'd0;
      wr_cnt_r <= 16'd0;
    end else begin
      if (rd_acc_s && in_range_s) begin
        rd_cnt_r <= sat_inc(rd_cnt_r);
      end
      if (wr_acc_s) begin
        wr_cnt_r <= sat_inc(wr_cnt_r);
      end
    end
  end

  assign rdata       = rdata_r;
  assign rdata_valid = rdata_valid_r;
  assign addr_err    = addr_err_r;
  assign rd_cnt      = rd_cnt_r;
  assign wr_cnt      = wr_cnt_r;

endmodule
